// File: rtl/cpu_pkg.sv
// Shared constants for the accumulator CPU: widths, opcodes and the
// control-unit state encoding.
package cpu_pkg;

    localparam int ADR_W  = 6;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JCC = 2'b11;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXE_UAL = 3'd3;
    localparam logic [2:0] S_STORE   = 3'd4;
    localparam logic [2:0] S_JUMP    = 3'd5;

endpackage

// File: rtl/control_unit.sv
// Instruction sequencer for the accumulator CPU: init, fetch, decode and
// one execute state per instruction class. Outputs are gated by ce and by
// rst so that every control line drops asynchronously with reset.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [1:0] opcode,
    input  logic       carry,
    output logic       clear_PC,
    output logic       enable_PC,
    output logic       load_PC,
    output logic       load_RI,
    output logic       sel_adr,
    output logic       mem_ce,
    output logic       mem_we,
    output logic       load_ACC,
    output logic       sel_UAL,
    output logic       load_carry,
    output logic       clear_carry,
    output logic [2:0] state_dbg
);

    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    logic [2:0] state, state_nx;
    logic [3:0] init_cnt, init_cnt_nx;
    logic       run;

    // Next state and init counter; everything holds while ce=0
    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        if (ce) begin
            init_cnt_nx = '0;
            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_LAST)
                        state_nx = S_FETCH;
                    else
                        init_cnt_nx = init_cnt + 4'd1;
                end
                S_FETCH:  state_nx = S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_STA:  state_nx = S_STORE;
                        OP_JCC:  state_nx = S_JUMP;
                        default: state_nx = S_EXE_UAL;
                    endcase
                end
                S_EXE_UAL, S_STORE, S_JUMP: state_nx = S_FETCH;
                default:  state_nx = S_INIT;
            endcase
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
        end
    end

    assign run       = ce & rst;
    assign state_dbg = state;

    // Output decode: Moore per state, plus opcode/carry in EXE_UAL and JUMP
    always_comb begin
        clear_PC    = 1'b0;
        enable_PC   = 1'b0;
        load_PC     = 1'b0;
        load_RI     = 1'b0;
        sel_adr     = 1'b0;
        mem_ce      = 1'b0;
        mem_we      = 1'b0;
        load_ACC    = 1'b0;
        sel_UAL     = 1'b0;
        load_carry  = 1'b0;
        clear_carry = 1'b0;
        if (run) begin
            case (state)
                S_INIT: begin
                    clear_PC    = 1'b1;
                    enable_PC   = 1'b1;
                    clear_carry = 1'b1;
                end
                S_FETCH: begin
                    mem_ce    = 1'b1;
                    load_RI   = 1'b1;
                    enable_PC = 1'b1;
                end
                S_DECODE: begin
                    mem_ce  = 1'b1;
                    sel_adr = 1'b1;
                end
                S_EXE_UAL: begin
                    load_ACC   = 1'b1;
                    sel_UAL    = opcode[0];
                    load_carry = opcode[0];
                end
                S_STORE: begin
                    mem_ce  = 1'b1;
                    mem_we  = 1'b1;
                    sel_adr = 1'b1;
                end
                S_JUMP: begin
                    load_PC     = ~carry;
                    clear_carry = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction sequencer for the accumulator CPU. It sits directly upstream of the program counter and drives its clear_PC, enable_PC and load_PC inputs.
- It also sequences the instruction register, memory, accumulator/ALU and carry flag through fetch, decode and execute.
- Instruction format is a 2-bit opcode plus a 6-bit operand address:
  - 00 NOR
  - 01 ADD
  - 10 STA
  - 11 JCC (jump if carry clear)

Parameters:
- INIT_CYCLES, 1: number of ce-qualified cycles spent in S_INIT after reset. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- ce  input  1  global clock enable; state advances only when ce=1.
- opcode  input  2  instruction register bits [7:6], valid from S_DECODE onward.
- carry  input  1  current carry flag value.
- clear_PC  output  1  to PC; clear when paired with enable_PC.
- enable_PC  output  1  to PC; increment (or clear with clear_PC).
- load_PC  output  1  to PC; load operand address.
- load_RI  output  1  instruction register load from memory data.
- sel_adr  output  1  memory address mux: 0 = PC, 1 = RI operand field.
- mem_ce  output  1  memory access enable (synchronous memory, 1-cycle read latency).
- mem_we  output  1  memory write (store accumulator).
- load_ACC  output  1  accumulator load from ALU result.
- sel_UAL  output  1  ALU function: 0 = NOR, 1 = ADD.
- load_carry  output  1  carry flag load from ALU carry-out.
- clear_carry  output  1  carry flag synchronous clear.
- state_dbg  output  3  current state encoding, for debug/verification.

Behaviour:
- States (3-bit): S_INIT=0, S_FETCH=1, S_DECODE=2, S_EXE_UAL=3, S_STORE=4, S_JUMP=5. Codes 6 and 7 are illegal and go to S_INIT on the next ce cycle.
- Reset (rst=0, asynchronous):
  - state=S_INIT, init counter=0.
  - All control outputs are 0 while rst=0. state_dbg=0.
- ce=0: state and counter hold. All control outputs forced 0; state_dbg still reflects the state.
- Outputs are Moore decodes of the state gated by ce, except in S_EXE_UAL and S_JUMP, which also use opcode/carry. Outputs not listed for a state are 0.
- S_INIT:
  - clear_PC=1, enable_PC=1, clear_carry=1.
  - Counter increments each ce cycle.
  - When counter==INIT_CYCLES-1, go to S_FETCH.
- S_FETCH:
  - mem_ce=1, sel_adr=0, load_RI=1, enable_PC=1 (PC post-increments).
  - Next: S_DECODE.
- S_DECODE:
  - mem_ce=1, sel_adr=1 (operand read is issued).
  - Next by opcode: 00/01 -> S_EXE_UAL, 10 -> S_STORE, 11 -> S_JUMP.
- S_EXE_UAL:
  - load_ACC=1, sel_UAL=opcode[0], load_carry=opcode[0] (ADD only; NOR leaves carry unchanged).
  - Next: S_FETCH.
- S_STORE:
  - mem_ce=1, mem_we=1, sel_adr=1.
  - Next: S_FETCH.
- S_JUMP:
  - load_PC = NOT carry; clear_carry=1 unconditionally.
  - Next: S_FETCH.
- Invariants:
  - load_PC and enable_PC are never both 1 (PC gives enable priority).
  - clear_PC=1 only together with enable_PC=1.
  - mem_we=1 implies mem_ce=1 and sel_adr=1.
- Instruction timing: NOR/ADD/STA/JCC each take exactly 3 ce cycles (FETCH, DECODE, execute).
- Reset asserted mid-instruction: immediate return to S_INIT with no partial write. mem_we drops asynchronously with rst.
- opcode is sampled only in S_DECODE and S_EXE_UAL. carry is sampled only in S_JUMP.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_NOR=2'b00, OP_ADD=2'b01, OP_STA=2'b10, OP_JCC=2'b11;
  - state encoding constants S_INIT..S_JUMP;
  - widths ADR_W=6, DATA_W=8.
- No sub-module. The init counter and the FSM live in one block: a next-state process and an output-decode process.

Test Plan:
- Reset release, INIT_CYCLES=3, ce=1 -> 3 cycles with clear_PC=enable_PC=clear_carry=1, then state_dbg=1 with load_RI=1, enable_PC=1.
- opcode=01 (ADD) -> state sequence 1,2,3. In state 3: load_ACC=1, sel_UAL=1, load_carry=1. Then back to state 1.
- opcode=10 (STA) -> in state 4: mem_we=1, mem_ce=1, sel_adr=1, load_ACC=0. opcode=00 -> state 3 with sel_UAL=0, load_carry=0.
- opcode=11 with carry=0 -> in state 5: load_PC=1, enable_PC=0, clear_carry=1. Repeat with carry=1 -> load_PC=0, clear_carry=1.
- ce toggled 1/0 every cycle through a full ADD -> sequence takes 6 clocks, and all control outputs are 0 in every ce=0 cycle.
- rst pulsed low during S_STORE -> mem_we falls before the next clock edge, state_dbg=0, then the INIT sequence restarts.
